// File: rtl/lz77_pkg.sv
// Shared types and helpers for the streaming LZ77 encoder.
//   lz77_state_e     : controller states
//   END_CHAR_DEFAULT : default string terminator ('$')
//   lz77_width()     : bit width needed to index `depth` entries (minimum 1)
package lz77_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StSearch,
    StEmit,
    StDone
  } lz77_state_e;

  localparam logic [7:0] END_CHAR_DEFAULT = 8'h24;

  function automatic int unsigned lz77_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lz77_match_len.sv
// Combinational match-length evaluator for a single candidate offset.
//   search     : search buffer, entry 0 is the newest symbol
//   search_vld : per-entry valid bits of the search buffer
//   look       : look-ahead buffer, entry 0 is the next symbol to encode
//   look_cnt   : number of occupied look-ahead entries
//   off        : candidate offset (0 = newest search entry)
//   len        : number of leading equal symbols, capped at look_cnt-1
module lz77_match_len #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SEARCH_LEN = 9,
  parameter int unsigned LOOK_LEN   = 8,
  parameter int unsigned OFF_W      = 4,
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned CNT_W      = 4
) (
  input  logic [SEARCH_LEN-1:0][DATA_W-1:0] search,
  input  logic [SEARCH_LEN-1:0]             search_vld,
  input  logic [LOOK_LEN-1:0][DATA_W-1:0]   look,
  input  logic [CNT_W-1:0]                  look_cnt,
  input  logic [OFF_W-1:0]                  off,
  output logic [LEN_W-1:0]                  len
);

  logic run;
  logic hit;

  // Look-ahead symbol i is compared against search[off-i] while that lies in the
  // search buffer, and against look[i-off-1] once the match overlaps the look-ahead.
  // The cap look_cnt-1 keeps at least one symbol available for char_nxt.
  always_comb begin
    len = '0;
    run = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < LOOK_LEN - 1; i++) begin
      hit = 1'b0;
      for (int k = 0; k < SEARCH_LEN; k++) begin
        if (k == int'(off) - i) hit = search_vld[k] && (search[k] == look[i]);
      end
      for (int k = 0; k < LOOK_LEN; k++) begin
        if (k == i - int'(off) - 1) hit = (look[k] == look[i]);
      end
      if (run && hit && (i + 1 < int'(look_cnt))) begin
        len = len + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lz77_encoder_stream.sv
// Streaming LZ77 encoder with a parametrised search window and look-ahead.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : symbol input handshake, chardata carries the symbol
//   valid/ready          : codeword output handshake
//   offset               : distance-1 back from the newest search entry
//   match_len            : match length (0 forces offset 0)
//   char_nxt             : symbol following the match (END_CHAR on the last codeword)
//   finish               : one-cycle pulse after the last codeword of a string
module lz77_encoder_stream
  import lz77_pkg::*;
#(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       SEARCH_LEN = 9,
  parameter int unsigned       LOOK_LEN   = 8,
  parameter logic [DATA_W-1:0] END_CHAR   = DATA_W'(END_CHAR_DEFAULT),
  localparam int unsigned      OFF_W      = lz77_width(SEARCH_LEN),
  localparam int unsigned      LEN_W      = lz77_width(LOOK_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] chardata,
  output logic              valid,
  input  logic              ready,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [DATA_W-1:0] char_nxt,
  output logic              finish
);

  localparam int unsigned      CNT_W    = lz77_width(LOOK_LEN + 1);
  localparam logic [CNT_W-1:0] LookFull = CNT_W'(LOOK_LEN);
  localparam logic [OFF_W-1:0] OffLast  = OFF_W'(SEARCH_LEN - 1);

  lz77_state_e state_q, state_d;

  logic [SEARCH_LEN-1:0][DATA_W-1:0] search_q, search_d;
  logic [SEARCH_LEN-1:0]             search_vld_q, search_vld_d;
  logic [LOOK_LEN-1:0][DATA_W-1:0]   look_q, look_d;
  logic [CNT_W-1:0]                  look_cnt_q, look_cnt_d;
  logic                              end_seen_q, end_seen_d;
  logic [OFF_W-1:0]                  srch_off_q, srch_off_d;
  logic [OFF_W-1:0]                  best_off_q, best_off_d;
  logic [LEN_W-1:0]                  best_len_q, best_len_d;
  logic [LEN_W-1:0]                  cand_len;
  logic [DATA_W-1:0]                 nxt_sym;
  int                                shift;

  lz77_match_len #(
    .DATA_W     (DATA_W),
    .SEARCH_LEN (SEARCH_LEN),
    .LOOK_LEN   (LOOK_LEN),
    .OFF_W      (OFF_W),
    .LEN_W      (LEN_W),
    .CNT_W      (CNT_W)
  ) u_match_len (
    .search     (search_q),
    .search_vld (search_vld_q),
    .look       (look_q),
    .look_cnt   (look_cnt_q),
    .off        (srch_off_q),
    .len        (cand_len)
  );

  always_comb begin
    nxt_sym = '0;
    for (int j = 0; j < LOOK_LEN; j++) begin
      if (j == int'(best_len_q)) nxt_sym = look_q[j];
    end
  end

  assign offset    = best_off_q;
  assign match_len = best_len_q;
  assign char_nxt  = nxt_sym;

  always_comb begin
    state_d      = state_q;
    search_d     = search_q;
    search_vld_d = search_vld_q;
    look_d       = look_q;
    look_cnt_d   = look_cnt_q;
    end_seen_d   = end_seen_q;
    srch_off_d   = srch_off_q;
    best_off_d   = best_off_q;
    best_len_d   = best_len_q;
    in_ready     = 1'b0;
    valid        = 1'b0;
    finish       = 1'b0;
    shift        = int'(best_len_q) + 1;

    unique case (state_q)
      StIdle: state_d = StFill;

      StFill: begin
        if (!end_seen_q && (look_cnt_q != LookFull)) begin
          in_ready = 1'b1;
          if (in_valid) begin
            for (int j = 0; j < LOOK_LEN; j++) begin
              if (j == int'(look_cnt_q)) look_d[j] = chardata;
            end
            look_cnt_d = look_cnt_q + 1'b1;
            if (chardata == END_CHAR) end_seen_d = 1'b1;
            if ((chardata == END_CHAR) || (look_cnt_q == LookFull - 1'b1)) begin
              state_d    = StSearch;
              srch_off_d = '0;
              best_off_d = '0;
              best_len_d = '0;
            end
          end
        end else begin
          // Look-ahead already full or terminated: nothing more to top up.
          state_d    = StSearch;
          srch_off_d = '0;
          best_off_d = '0;
          best_len_d = '0;
        end
      end

      StSearch: begin
        // Strictly longer wins, so ties keep the smaller offset.
        if (cand_len > best_len_q) begin
          best_len_d = cand_len;
          best_off_d = srch_off_q;
        end
        if (srch_off_q == OffLast) begin
          state_d = StEmit;
        end else begin
          srch_off_d = srch_off_q + 1'b1;
        end
      end

      StEmit: begin
        valid = 1'b1;
        if (ready) begin
          // Matched symbols plus char_nxt move into the search buffer, newest at entry 0.
          for (int k = 0; k < SEARCH_LEN; k++) begin
            for (int j = 0; j < LOOK_LEN; j++) begin
              if ((k < shift) && (j == shift - 1 - k)) begin
                search_d[k]     = look_q[j];
                search_vld_d[k] = 1'b1;
              end
            end
            for (int m = 0; m < SEARCH_LEN; m++) begin
              if ((k >= shift) && (m == k - shift)) begin
                search_d[k]     = search_q[m];
                search_vld_d[k] = search_vld_q[m];
              end
            end
          end
          for (int j = 0; j < LOOK_LEN; j++) begin
            look_d[j] = '0;
            for (int m = 0; m < LOOK_LEN; m++) begin
              if (m == j + shift) look_d[j] = look_q[m];
            end
          end
          look_cnt_d = look_cnt_q - CNT_W'(shift);
          state_d    = (nxt_sym == END_CHAR) ? StDone : StFill;
        end
      end

      StDone: begin
        finish       = 1'b1;
        search_d     = '0;
        search_vld_d = '0;
        look_d       = '0;
        look_cnt_d   = '0;
        end_seen_d   = 1'b0;
        state_d      = StFill;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      search_q     <= '0;
      search_vld_q <= '0;
      look_q       <= '0;
      look_cnt_q   <= '0;
      end_seen_q   <= 1'b0;
      srch_off_q   <= '0;
      best_off_q   <= '0;
      best_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      search_q     <= search_d;
      search_vld_q <= search_vld_d;
      look_q       <= look_d;
      look_cnt_q   <= look_cnt_d;
      end_seen_q   <= end_seen_d;
      srch_off_q   <= srch_off_d;
      best_off_q   <= best_off_d;
      best_len_q   <= best_len_d;
    end
  end

endmodule

// File: tb/tb_lz77_encoder_stream.sv
// Self-checking bench for lz77_encoder_stream against a greedy LZ77 reference model.
module tb_lz77_encoder_stream;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned SEARCH_LEN = 9;
  localparam int unsigned LOOK_LEN   = 8;
  localparam int unsigned OFF_W      = 4;
  localparam int unsigned LEN_W      = 3;
  localparam logic [7:0]  END        = 8'h24;

  typedef struct packed {
    logic [OFF_W-1:0]  off;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] ch;
  } cw_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] chardata = '0;
  logic              valid;
  logic              ready = 1'b0;
  logic [OFF_W-1:0]  offset;
  logic [LEN_W-1:0]  match_len;
  logic [DATA_W-1:0] char_nxt;
  logic              finish;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] str[$];
  logic [7:0] src_q[$];
  cw_t        exp_q[$];

  lz77_encoder_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chardata  (chardata),
    .valid     (valid),
    .ready     (ready),
    .offset    (offset),
    .match_len (match_len),
    .char_nxt  (char_nxt),
    .finish    (finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    str.delete();
    for (int i = 0; i < s.len(); i++) str.push_back(s[i]);
  endtask

  // Greedy LZ77: window is the last SEARCH_LEN symbols of this string, matches may
  // overlap the current position, length capped at LOOK_LEN-1 and at the symbols left.
  task automatic model_string();
    int  n;
    int  pos;
    int  best_len;
    int  best_d;
    int  cap;
    int  l;
    cw_t cw;
    n   = str.size();
    pos = 0;
    exp_q.delete();
    forever begin
      best_len = 0;
      best_d   = 1;
      cap      = n - pos;
      if (cap > int'(LOOK_LEN) - 1) cap = int'(LOOK_LEN) - 1;
      for (int d = 1; d <= int'(SEARCH_LEN) && d <= pos; d++) begin
        l = 0;
        while (l < cap && str[pos - d + l] == str[pos + l]) l++;
        if (l > best_len) begin
          best_len = l;
          best_d   = d;
        end
      end
      cw.off = (best_len == 0) ? '0 : OFF_W'(best_d - 1);
      cw.len = LEN_W'(best_len);
      cw.ch  = (pos + best_len < n) ? str[pos + best_len] : END;
      exp_q.push_back(cw);
      if (pos + best_len >= n) break;
      pos += best_len + 1;
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready held low for 5 valid cycles.
  // abort_after >= 0 returns 4 cycles after that many codewords (for the reset test).
  task automatic run_string(input int mode, input int abort_after, input int junk);
    int  cycles;
    int  n_cw;
    int  stalls;
    int  tail;
    bit  fin_due;
    bit  done;
    bit  stalled;
    cw_t cw;
    cw_t held;
    cycles  = 0;
    n_cw    = 0;
    stalls  = 5;
    tail    = 0;
    fin_due = 0;
    done    = 0;
    stalled = 0;
    held    = '0;
    model_string();
    src_q = str;
    src_q.push_back(END);
    for (int i = 0; i < junk; i++) src_q.push_back(8'h41);
    while (!done && cycles < 4000) begin
      @(negedge clk);
      cycles++;
      if (abort_after >= 0 && n_cw >= abort_after) begin
        if (tail == 4) begin
          in_valid = 1'b0;
          src_q.delete();
          return;
        end
        tail++;
      end
      if (stalled) begin
        chk("stall_valid", 32'(valid), 32'd1);
        chk("stall_hold", 32'({offset, match_len, char_nxt}), 32'(held));
        chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (fin_due) begin
        chk("finish_pulse", 32'(finish), 32'd1);
        done     = 1;
        in_valid = 1'b0;
        ready    = 1'b0;
        break;
      end
      chk("finish_idle", 32'(finish), 32'd0);
      in_valid = (src_q.size() != 0);
      chardata = in_valid ? src_q[0] : '0;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = !(valid && stalls > 0);
      endcase
      if (mode == 2 && valid && stalls > 0) stalls--;
      if (in_valid && in_ready) void'(src_q.pop_front());
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_codeword", 32'd1, 32'd0);
        end else begin
          cw = exp_q.pop_front();
          chk("offset", 32'(offset), 32'(cw.off));
          chk("match_len", 32'(match_len), 32'(cw.len));
          chk("char_nxt", 32'(char_nxt), 32'(cw.ch));
          if (cw.ch == END) fin_due = 1;
        end
        n_cw++;
      end
      stalled = valid && !ready;
      held    = {offset, match_len, char_nxt};
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("codewords_left", 32'(exp_q.size()), 32'd0);
    chk("symbols_left", 32'(src_q.size()), 32'(junk));
    @(negedge clk);
    chk("finish_once", 32'(finish), 32'd0);
    src_q.delete();
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_offset", 32'(offset), 32'd0);
    chk("rst_match_len", 32'(match_len), 32'd0);
    chk("rst_char_nxt", 32'(char_nxt), 32'd0);
  endtask

  initial begin
    int len;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_state();
    reset = 1'b0;

    load("0123");
    run_string(0, -1, 1);
    load("0000");
    run_string(0, -1, 0);
    str.delete();
    for (int i = 0; i < 20; i++) str.push_back(8'h30);
    run_string(0, -1, 0);
    load("0101");
    run_string(2, -1, 0);
    load("");
    run_string(0, -1, 0);

    // Reset while searching the second codeword; a stale '0' would yield (0,1,'$').
    load("0000000000");
    run_string(0, 1, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state();
    reset = 1'b0;
    load("0");
    run_string(0, -1, 0);

    for (int s = 0; s < 8; s++) begin
      str.delete();
      len = $urandom_range(0, 24);
      for (int i = 0; i < len; i++) str.push_back(8'h30 + 8'($urandom_range(0, 2)));
      run_string(1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
